// File: rtl/parking_lane_scheduler_pkg.sv
// Shared constants and FSM encoding for the parking lane scheduler and its lane front-ends.
package parking_lane_scheduler_pkg;

  localparam int unsigned DefNumLanes  = 4;
  localparam int unsigned DefCapacity  = 16;
  localparam int unsigned DefCntW      = 5;
  localparam int unsigned DefOpenCycles = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StOpen  = 2'b01,
    StClose = 2'b10
  } state_e;

endpackage

// File: rtl/parking_lane_scheduler_if.sv
// Lane/gate bundle between the lane front-ends (master) and the scheduler (slave).
interface parking_lane_scheduler_if
  import parking_lane_scheduler_pkg::*;
#(
  parameter int unsigned NUM_LANES = DefNumLanes,
  parameter int unsigned CNT_W     = DefCntW
);

  logic [NUM_LANES-1:0] req;
  logic [NUM_LANES-1:0] req_entry;
  logic                 car_passed;
  logic [NUM_LANES-1:0] grant;
  logic                 gate_open;
  logic [NUM_LANES-1:0] done;
  logic                 timeout;
  logic [CNT_W-1:0]     occupancy;
  logic                 full;
  logic                 empty;

  modport master (
    output req, req_entry, car_passed,
    input  grant, gate_open, done, timeout, occupancy, full, empty
  );

  modport slave (
    input  req, req_entry, car_passed,
    output grant, gate_open, done, timeout, occupancy, full, empty
  );

endinterface

// File: rtl/parking_lane_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first eligible lane at or after the pointer, wrapping.
module parking_lane_scheduler_rr_arbiter #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned IdxW      = 2
) (
  input  logic [NUM_LANES-1:0] elig_i,
  input  logic [IdxW-1:0]      ptr_i,
  output logic [NUM_LANES-1:0] gnt_o,
  output logic [IdxW-1:0]      idx_o,
  output logic                 valid_o
);

  logic            found;
  logic [IdxW-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      k = IdxW'((32'(ptr_i) + i) % NUM_LANES);
      if (!found && elig_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

  assign valid_o = |elig_i;

endmodule

// File: rtl/parking_lane_scheduler.sv
// Shares one barrier gate and occupancy counter between lanes: arbitrate, open, await car or
// timeout, then update occupancy.
module parking_lane_scheduler
  import parking_lane_scheduler_pkg::*;
#(
  parameter int unsigned NUM_LANES   = DefNumLanes,
  parameter int unsigned CAPACITY    = DefCapacity,
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned OPEN_CYCLES = DefOpenCycles
) (
  input logic                    clk,
  input logic                    reset,
  parking_lane_scheduler_if.slave bus
);

  localparam int unsigned IdxW   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned TimerW = $clog2(OPEN_CYCLES + 1);

  state_e               state_q;
  logic [NUM_LANES-1:0] grant_q;
  logic [NUM_LANES-1:0] done_q;
  logic                 gate_open_q;
  logic                 timeout_q;
  logic [CNT_W-1:0]     occ_q;
  logic [IdxW-1:0]      ptr_q;
  logic [IdxW-1:0]      win_q;
  logic                 dir_q;
  logic [TimerW-1:0]    timer_q;

  logic                 full;
  logic                 empty;
  logic [NUM_LANES-1:0] elig;
  logic [NUM_LANES-1:0] arb_gnt;
  logic [IdxW-1:0]      arb_idx;
  logic                 arb_valid;

  assign full  = (occ_q == CNT_W'(CAPACITY));
  assign empty = (occ_q == '0);

  // Masking at the request keeps occupancy inside [0, CAPACITY] without saturation logic.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      elig[i] = bus.req[i] & (bus.req_entry[i] ? !full : !empty);
    end
  end

  parking_lane_scheduler_rr_arbiter #(
    .NUM_LANES (NUM_LANES),
    .IdxW      (IdxW)
  ) u_arb (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      done_q      <= '0;
      gate_open_q <= 1'b0;
      timeout_q   <= 1'b0;
      occ_q       <= '0;
      ptr_q       <= '0;
      win_q       <= '0;
      dir_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      done_q    <= '0;
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            win_q       <= arb_idx;
            dir_q       <= bus.req_entry[arb_idx];
            grant_q     <= arb_gnt;
            gate_open_q <= 1'b1;
            timer_q     <= '0;
            state_q     <= StOpen;
          end
        end
        StOpen: begin
          // car_passed takes priority over the final timer cycle.
          if (bus.car_passed) begin
            done_q      <= grant_q;
            occ_q       <= dir_q ? occ_q + CNT_W'(1) : occ_q - CNT_W'(1);
            grant_q     <= '0;
            gate_open_q <= 1'b0;
            state_q     <= StClose;
          end else if (timer_q == TimerW'(OPEN_CYCLES - 1)) begin
            timeout_q   <= 1'b1;
            grant_q     <= '0;
            gate_open_q <= 1'b0;
            state_q     <= StClose;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end
        StClose: begin
          ptr_q   <= (win_q == IdxW'(NUM_LANES - 1)) ? '0 : win_q + IdxW'(1);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.gate_open = gate_open_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.occupancy = occ_q;
  assign bus.full      = full;
  assign bus.empty     = empty;

endmodule
